key_press_classifier: RTL
=========================

# key_press_classifier

Upstream key front-end for the counter/display path: takes one raw push-button level, synchronises and debounces it, and classifies presses into single-cycle event pulses. The events are press, release, short, long and auto-repeat. It feeds the key-driven counters that in turn drive the digit display, replacing ad-hoc rise/fall detection with one uniform event source per key.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency in Hz.
- `DEB_MS`, default 15: debounce stability window in ms.
- `LONG_MS`, default 1000: hold time in ms before `long_pulse`.
- `REPEAT_MS`, default 200: auto-repeat period in ms after `long_pulse`.
- `KEY_ACTIVE`, default 1'b1: raw `key_in` level meaning "pressed".

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `key_in` in 1: raw asynchronous button level.
- `key_level` out 1: debounced level, 1 = pressed, independent of `KEY_ACTIVE`.
- `press_pulse` out 1: one cycle, debounced press.
- `release_pulse` out 1: one cycle, debounced release.
- `short_pulse` out 1: one cycle, release before long threshold.
- `long_pulse` out 1: one cycle, hold reached `LONG_MS`.
- `repeat_pulse` out 1: one cycle, every `REPEAT_MS` while held after long.

## Operation
- Derived cycle counts:
  - DEB_CYC = max(1, CLK_HZ/1000*DEB_MS).
  - LONG_CYC = CLK_HZ/1000*LONG_MS.
  - REP_CYC = CLK_HZ/1000*REPEAT_MS.
  - Counter widths are $clog2 of the respective count plus 1. No wrap is permitted before a threshold.
- Input conditioning:
  - `key_in` passes through a 2-flop synchroniser.
  - It is then normalised by `KEY_ACTIVE` so that 1 = pressed.
- Debounce:
  - The stability counter clears whenever the synchronised level equals `key_level`.
  - Otherwise it increments.
  - When it reaches DEB_CYC, `key_level` toggles and the counter clears.
  - Any disagreement shorter than DEB_CYC is discarded.
- FSM states:
  - IDLE: waiting for a debounced press.
  - PRESSED: counting hold time.
  - LONG_HELD: auto-repeat.
- FSM transitions:
  - IDLE → PRESSED on debounced rise. Assert `press_pulse`, clear the hold counter.
  - PRESSED, hold counter reaches LONG_CYC → LONG_HELD. Assert `long_pulse`, clear the hold counter.
  - PRESSED, debounced fall → IDLE. Assert `release_pulse` and `short_pulse`.
  - LONG_HELD, hold counter reaches REP_CYC → assert `repeat_pulse`, clear the hold counter, stay in LONG_HELD.
  - LONG_HELD, debounced fall → IDLE. Assert `release_pulse` only.
- Boundary conditions:
  - Debounced fall on the same cycle a threshold would be reached: release wins. `short_pulse` (from PRESSED) or no repeat (from LONG_HELD); no `long_pulse` or `repeat_pulse` that cycle.
  - LONG_MS = 0 is not supported. REPEAT_MS = 0 disables repeat; the hold counter stops in LONG_HELD.
  - At most one of `press`/`long`/`repeat` is high in any cycle. `short_pulse` is high only together with `release_pulse`.
- Reset (asynchronous, any time, including mid-press):
  - All outputs, the synchroniser, counters and state go to 0/IDLE.
  - A key still held at reset deassertion is treated as a new press after the full debounce.

## Timing
- Every output is registered; pulses are exactly one clock wide.
- `key_in` edge to `key_level` change: 2 + DEB_CYC cycles, on a clean edge.
- `press_pulse` and `release_pulse` are asserted in the same cycle that `key_level` first shows the new value. `short_pulse` coincides with `release_pulse`.
- `long_pulse` is asserted LONG_CYC cycles after `press_pulse`.
- The first `repeat_pulse` comes REP_CYC cycles after `long_pulse`, then every REP_CYC cycles.
- No combinational path from `key_in` to any output.

## Structure
- Shared package `key_evt_pkg`:
  - FSM state enum (IDLE, PRESSED, LONG_HELD).
  - Function `ms_to_cyc(clk_hz, ms)`.
  - Reused by other key front-ends.
- Sub-module `key_sync_debounce`: synchroniser, polarity normalisation and debounce counter, outputting `key_level` and a one-cycle change strobe.
- The classifier FSM and hold counter live in the top module.

## Test plan
All scenarios use CLK_HZ=1000, DEB_MS=3, LONG_MS=20, REPEAT_MS=5, giving DEB_CYC=3, LONG_CYC=20, REP_CYC=5.
1. Hold `rst`=0 with `key_in` toggling → all outputs 0. Deassert with `key_in`=0 → outputs stay 0.
2. Bounce: `key_in` 1,0,1 on successive cycles, then steady 1 → exactly one `press_pulse`, 5 cycles after the last edge. No pulses during the bounce.
3. Short press: release 10 cycles after `press_pulse` → `release_pulse` and `short_pulse` together, 5 cycles after `key_in` falls. No `long_pulse`.
4. Long hold of 32 cycles after `press_pulse` → `long_pulse` at +20, `repeat_pulse` at +25 and +30. Release → `release_pulse` only, `short_pulse` stays 0.
5. Glitch: a 2-cycle low on `key_in` during a hold → no release. `key_level` stays 1 and the long/repeat schedule is unchanged.
6. Reset mid-hold at +22 with the key still pressed → all outputs 0 immediately. After deassert, `press_pulse` 5 cycles later and `long_pulse` 20 cycles after that.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared definitions for key front-ends: classifier state encoding and the
// millisecond-to-clock-cycle conversion used to size every timer.
package key_evt_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } key_state_t;

   function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/key_press_classifier_if.sv
// Raw key input plus the debounced level and the five event pulses of one key.
interface key_press_classifier_if;

   logic key_in;
   logic key_level;
   logic press_pulse;
   logic release_pulse;
   logic short_pulse;
   logic long_pulse;
   logic repeat_pulse;

   modport master (
      output key_in,
      input  key_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
   );

   modport slave (
      input  key_in,
      output key_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
   );

endinterface

// File: rtl/key_sync_debounce.sv
// Two-flop synchroniser, polarity normalisation and stability-window debounce.
// change is high in the cycle before key_level flips, so registered event pulses line up with it.
module key_sync_debounce #(
   parameter int unsigned DEB_CYC    = 1,
   parameter logic        KEY_ACTIVE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic change
);

   localparam int CNT_W = $clog2(DEB_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

   logic [1:0]       sync_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             level_reg;
   logic             pressed;

   assign pressed   = (sync_reg[1] == KEY_ACTIVE);
   assign change    = (pressed != level_reg) && (cnt_reg == CNT_LAST);
   assign key_level = level_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg  <= '0;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], key_in};
         // Any agreement restarts the window, so short disagreements are dropped.
         if (pressed == level_reg) begin
            cnt_reg <= '0;
         end else if (change) begin
            level_reg <= ~level_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_press_classifier.sv
// Turns one raw push-button into debounced press/release/short/long/repeat pulses.
// Hold counter is shared between the long threshold and the auto-repeat period.
module key_press_classifier
   import key_evt_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned DEB_MS     = 15,
   parameter int unsigned LONG_MS    = 1000,
   parameter int unsigned REPEAT_MS  = 200,
   parameter logic        KEY_ACTIVE = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   key_press_classifier_if.slave  bus
);

   localparam int unsigned DEB_RAW   = ms_to_cyc(CLK_HZ, DEB_MS);
   localparam int unsigned DEB_CYC   = (DEB_RAW == 0) ? 1 : DEB_RAW;
   localparam int unsigned LONG_CYC  = ms_to_cyc(CLK_HZ, LONG_MS);
   localparam int unsigned REP_CYC   = ms_to_cyc(CLK_HZ, REPEAT_MS);
   localparam int unsigned HOLD_MAX  = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
   localparam int          HOLD_W    = $clog2(HOLD_MAX) + 1;
   localparam int unsigned LONG_LAST = (LONG_CYC == 0) ? 0 : LONG_CYC - 1;
   localparam int unsigned REP_LAST  = (REP_CYC == 0) ? 0 : REP_CYC - 1;

   logic              level;
   logic              change;
   logic              rise;
   logic              fall;
   key_state_t        state_reg;
   logic [HOLD_W-1:0] hold_reg;
   logic              press_reg;
   logic              release_reg;
   logic              short_reg;
   logic              long_reg;
   logic              repeat_reg;

   key_sync_debounce #(
      .DEB_CYC    (DEB_CYC),
      .KEY_ACTIVE (KEY_ACTIVE)
   ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .key_in    (bus.key_in),
      .key_level (level),
      .change    (change)
   );

   assign rise = change && !level;
   assign fall = change && level;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         hold_reg    <= '0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
         short_reg   <= 1'b0;
         long_reg    <= 1'b0;
         repeat_reg  <= 1'b0;
      end else begin
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
         short_reg   <= 1'b0;
         long_reg    <= 1'b0;
         repeat_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rise) begin
                  state_reg <= PRESSED;
                  press_reg <= 1'b1;
                  hold_reg  <= '0;
               end
            end
            PRESSED: begin
               // A release landing on the threshold cycle is still a short press.
               if (fall) begin
                  state_reg   <= IDLE;
                  release_reg <= 1'b1;
                  short_reg   <= 1'b1;
               end else if (hold_reg == HOLD_W'(LONG_LAST)) begin
                  state_reg <= LONG_HELD;
                  long_reg  <= 1'b1;
                  hold_reg  <= '0;
               end else begin
                  hold_reg <= hold_reg + 1'b1;
               end
            end
            LONG_HELD: begin
               if (fall) begin
                  state_reg   <= IDLE;
                  release_reg <= 1'b1;
               end else if (REP_CYC != 0) begin
                  if (hold_reg == HOLD_W'(REP_LAST)) begin
                     repeat_reg <= 1'b1;
                     hold_reg   <= '0;
                  end else begin
                     hold_reg <= hold_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.key_level     = level;
   assign bus.press_pulse   = press_reg;
   assign bus.release_pulse = release_reg;
   assign bus.short_pulse   = short_reg;
   assign bus.long_pulse    = long_reg;
   assign bus.repeat_pulse  = repeat_reg;

endmodule
